// File: rtl/cpu_pkg.sv
// Shared widths, the zero-register index and the load-queue entry layout
// used by the register-file write-back path.
package cpu_pkg;

   localparam int CPU_DATA_W = 32;
   localparam int CPU_ADDR_W = 5;

   localparam logic [CPU_ADDR_W-1:0] REG_ZERO = '0;

   // One outstanding load: destination, returned data, data-has-arrived flag.
   typedef struct packed {
      logic [CPU_ADDR_W-1:0] rd;
      logic [CPU_DATA_W-1:0] data;
      logic                  done;
   } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Execute/memory side handshake plus the register-file write port of the
// write-back controller. The master drives requests; the slave is the controller.
interface regfile_writeback_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);

   logic              alu_valid;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              ld_issue;
   logic [ADDR_W-1:0] ld_rd;
   logic              ld_ready;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic [ADDR_W-1:0] src_1;
   logic [ADDR_W-1:0] src_2;
   logic              busy_1;
   logic              busy_2;
   logic              regwrite;
   logic [ADDR_W-1:0] register_w;
   logic [DATA_W-1:0] write_data;
   logic              proto_err;

   modport master (
      output alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_valid, ld_data,
             src_1, src_2,
      input  ld_ready, busy_1, busy_2, regwrite, register_w, write_data, proto_err
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_valid, ld_data,
             src_1, src_2,
      output ld_ready, busy_1, busy_2, regwrite, register_w, write_data, proto_err
   );

endinterface

// File: rtl/wb_queue.sv
// In-order outstanding-load queue. Entries live between head and tail;
// entries between head and ret have their data back. Three independent
// pointers let issue, return and drain all act in the same cycle.
module wb_queue
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_issue,
   input  logic [ADDR_W-1:0] i_issue_rd,
   input  logic              i_ret,
   input  logic [DATA_W-1:0] i_ret_data,
   input  logic              i_pop,
   input  logic [ADDR_W-1:0] i_src_1,
   input  logic [ADDR_W-1:0] i_src_2,
   output logic              o_full,
   output logic              o_ret_avail,
   output logic              o_head_done,
   output logic [ADDR_W-1:0] o_head_rd,
   output logic [DATA_W-1:0] o_head_data,
   output logic [DEPTH-1:0]  o_match_1,
   output logic [DEPTH-1:0]  o_match_2
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        r_entry [DEPTH];
   logic [PTR_W:0]   r_head;
   logic [PTR_W:0]   r_ret;
   logic [PTR_W:0]   r_tail;

   logic [PTR_W:0]   w_count;
   logic             w_empty;
   logic             w_issue_ok;
   logic             w_ret_ok;
   logic             w_pop_ok;
   logic [DEPTH-1:0] w_valid;

   assign w_count     = r_tail - r_head;
   assign w_empty     = (r_head == r_tail);
   assign o_full      = (w_count == (PTR_W+1)'(DEPTH));
   assign o_ret_avail = (r_ret != r_tail);

   assign w_issue_ok  = i_issue & ~o_full;
   assign w_ret_ok    = i_ret & o_ret_avail;

   assign o_head_rd   = r_entry[r_head[PTR_W-1:0]].rd;
   assign o_head_data = r_entry[r_head[PTR_W-1:0]].data;
   assign o_head_done = ~w_empty & r_entry[r_head[PTR_W-1:0]].done;
   assign w_pop_ok    = i_pop & o_head_done;

   // An entry is live when its distance from head (mod DEPTH) is below count.
   for (genvar g = 0; g < DEPTH; g++) begin : g_match
      assign w_valid[g]   = ({1'b0, PTR_W'(g) - r_head[PTR_W-1:0]} < w_count);
      assign o_match_1[g] = w_valid[g] & (r_entry[g].rd == i_src_1);
      assign o_match_2[g] = w_valid[g] & (r_entry[g].rd == i_src_2);
   end

   // Pointer advance; each pointer moves on its own event.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_head <= '0;
         r_ret  <= '0;
         r_tail <= '0;
      end else begin
         if (w_issue_ok) r_tail <= r_tail + (PTR_W+1)'(1);
         if (w_ret_ok)   r_ret  <= r_ret  + (PTR_W+1)'(1);
         if (w_pop_ok)   r_head <= r_head + (PTR_W+1)'(1);
      end
   end

   // Entry storage. Issue, return and pop never hit the same slot in one
   // cycle: issue needs not-full, return needs ret!=tail, pop needs head<ret.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_issue_ok && r_tail[PTR_W-1:0] == PTR_W'(i)) begin
               r_entry[i].rd   <= i_issue_rd;
               r_entry[i].done <= 1'b0;
            end
            if (w_ret_ok && r_ret[PTR_W-1:0] == PTR_W'(i)) begin
               r_entry[i].data <= i_ret_data;
               r_entry[i].done <= 1'b1;
            end
            if (w_pop_ok && r_head[PTR_W-1:0] == PTR_W'(i)) begin
               r_entry[i].done <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back controller: arbitrates ALU results against
// completed loads onto the single registered write port, publishes RAW
// busy flags for decode and latches protocol violations.
module regfile_writeback
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic               clock,
   input  logic               reset,
   regfile_writeback_if.slave bus
);

   logic              w_full;
   logic              w_ret_avail;
   logic              w_head_done;
   logic [ADDR_W-1:0] w_head_rd;
   logic [DATA_W-1:0] w_head_data;
   logic [DEPTH-1:0]  w_match_1;
   logic [DEPTH-1:0]  w_match_2;
   logic              w_pop;

   logic              r_regwrite;
   logic [ADDR_W-1:0] r_register_w;
   logic [DATA_W-1:0] r_write_data;
   logic              r_proto_err;

   // The ALU has no buffering, so it always owns the port; a ready load waits.
   assign w_pop = ~bus.alu_valid & w_head_done;

   wb_queue #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_queue (
      .clock       (clock),
      .reset       (reset),
      .i_issue     (bus.ld_issue),
      .i_issue_rd  (bus.ld_rd),
      .i_ret       (bus.ld_valid),
      .i_ret_data  (bus.ld_data),
      .i_pop       (w_pop),
      .i_src_1     (bus.src_1),
      .i_src_2     (bus.src_2),
      .o_full      (w_full),
      .o_ret_avail (w_ret_avail),
      .o_head_done (w_head_done),
      .o_head_rd   (w_head_rd),
      .o_head_data (w_head_data),
      .o_match_1   (w_match_1),
      .o_match_2   (w_match_2)
   );

   // Registered write port; index/data hold when nothing is written.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_regwrite   <= 1'b0;
         r_register_w <= '0;
         r_write_data <= '0;
      end else if (bus.alu_valid) begin
         r_regwrite   <= (bus.alu_rd != REG_ZERO);
         r_register_w <= bus.alu_rd;
         r_write_data <= bus.alu_data;
      end else if (w_pop) begin
         r_regwrite   <= (w_head_rd != REG_ZERO);
         r_register_w <= w_head_rd;
         r_write_data <= w_head_data;
      end else begin
         r_regwrite   <= 1'b0;
      end
   end

   // Sticky flag for an issue into a full queue or a return with nothing owed.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_proto_err <= 1'b0;
      end else if ((bus.ld_issue & w_full) | (bus.ld_valid & ~w_ret_avail)) begin
         r_proto_err <= 1'b1;
      end
   end

   assign bus.regwrite   = r_regwrite;
   assign bus.register_w = r_register_w;
   assign bus.write_data = r_write_data;
   assign bus.proto_err  = r_proto_err;
   assign bus.ld_ready   = ~w_full;
   assign bus.busy_1     = (bus.src_1 != REG_ZERO) & (|w_match_1);
   assign bus.busy_2     = (bus.src_2 != REG_ZERO) & (|w_match_2);

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and randomized checks of the write-back controller against a
// queue-based reference model of its documented behaviour.
module tb_regfile_writeback;
   import cpu_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
      bit            done;
   } m_ent_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   regfile_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   regfile_writeback #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   m_ent_t        mq[$];
   logic          m_rw;
   logic [AW-1:0] m_w;
   logic [DW-1:0] m_d;
   logic          m_err;
   int            n_cmp = 0;
   int            n_bad = 0;

   function automatic bit m_pending(input logic [AW-1:0] rd);
      if (rd == 0) return 1'b0;
      foreach (mq[i]) if (mq[i].rd == rd) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_unreturned();
      int n = 0;
      foreach (mq[i]) if (!mq[i].done) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                        input bit iss, input logic [AW-1:0] ird,
                        input bit lv, input logic [DW-1:0] ld,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2);
      bus.alu_valid = av;
      bus.alu_rd    = ard;
      bus.alu_data  = ad;
      bus.ld_issue  = iss;
      bus.ld_rd     = ird;
      bus.ld_valid  = lv;
      bus.ld_data   = ld;
      bus.src_1     = s1;
      bus.src_2     = s2;
   endtask

   task automatic chk_regs();
      chk("regwrite",   DW'(bus.regwrite),   DW'(m_rw));
      chk("register_w", DW'(bus.register_w), DW'(m_w));
      chk("write_data", bus.write_data,      m_d);
      chk("proto_err",  DW'(bus.proto_err),  DW'(m_err));
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, advance
   // the model at posedge, then check the registered outputs.
   task automatic step(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input bit iss, input logic [AW-1:0] ird,
                       input bit lv, input logic [DW-1:0] ld,
                       input logic [AW-1:0] s1, input logic [AW-1:0] s2);
      bit pop, full, found;
      @(negedge clock);
      drive(av, ard, ad, iss, ird, lv, ld, s1, s2);
      if (av) assert (!m_pending(ard)) else $error("WAW guard: alu_rd %0d has a pending load", ard);
      #1;
      chk("ld_ready", DW'(bus.ld_ready), DW'(mq.size() < DEPTH));
      chk("busy_1",   DW'(bus.busy_1),   DW'(m_pending(s1)));
      chk("busy_2",   DW'(bus.busy_2),   DW'(m_pending(s2)));
      @(posedge clock);
      pop  = !av && mq.size() > 0 && mq[0].done;
      full = (mq.size() >= DEPTH);
      if (av) begin
         m_rw = (ard != 0); m_w = ard; m_d = ad;
      end else if (pop) begin
         m_rw = (mq[0].rd != 0); m_w = mq[0].rd; m_d = mq[0].data;
      end else begin
         m_rw = 1'b0;
      end
      if (lv) begin
         found = 1'b0;
         foreach (mq[i]) if (!found && !mq[i].done) begin
            mq[i].done = 1'b1; mq[i].data = ld; found = 1'b1;
         end
         if (!found) m_err = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (iss) begin
         if (full) m_err = 1'b1;
         else mq.push_back('{rd: ird, data: '0, done: 1'b0});
      end
      #1;
      chk_regs();
   endtask

   task automatic idle(input logic [AW-1:0] s1, input logic [AW-1:0] s2);
      step(0, 0, 0, 0, 0, 0, 0, s1, s2);
   endtask

   // Asynchronous reset pulse away from the clock edge.
   task automatic do_reset(input logic [AW-1:0] s1);
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0, 0, s1, 0);
      #2 reset = 1'b0;
      mq.delete();
      m_rw = 1'b0; m_w = '0; m_d = '0; m_err = 1'b0;
      #1;
      chk_regs();
      chk("rst_ld_ready", DW'(bus.ld_ready), DW'(1));
      chk("rst_busy_1",   DW'(bus.busy_1),   DW'(0));
      chk("rst_busy_2",   DW'(bus.busy_2),   DW'(0));
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      bit            av, iss, lv;
      logic [AW-1:0] ard, ird, s1, s2;

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset(0);

      // ALU-only write
      step(1, 3, 'h55, 0, 0, 0, 0, 0, 0);
      chk("alu_rw", DW'(bus.regwrite),   DW'(1));
      chk("alu_w",  DW'(bus.register_w), DW'(3));
      chk("alu_d",  bus.write_data,      DW'('h55));

      // Load to r5, data two cycles after issue
      step(0, 0, 0, 1, 5, 0, 0, 5, 0);
      idle(5, 0);
      chk("ld_busy", DW'(bus.busy_1), DW'(1));
      step(0, 0, 0, 0, 0, 1, 'hAB, 5, 0);
      idle(5, 0);
      chk("ld_rw",       DW'(bus.regwrite),   DW'(1));
      chk("ld_w",        DW'(bus.register_w), DW'(5));
      chk("ld_d",        bus.write_data,      DW'('hAB));
      chk("ld_busy_clr", DW'(bus.busy_1),     DW'(0));

      // Load return to r6 collides with ALU write to r7
      step(0, 0, 0, 1, 6, 0, 0, 0, 6);
      idle(0, 6);
      step(1, 7, 'h77, 0, 0, 1, 'h66, 0, 6);
      chk("cf_alu_w", DW'(bus.register_w), DW'(7));
      chk("cf_alu_d", bus.write_data,      DW'('h77));
      idle(0, 6);
      chk("cf_ld_w", DW'(bus.register_w), DW'(6));
      chk("cf_ld_d", bus.write_data,      DW'('h66));

      // Fill the queue, overflow it, then drain
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, AW'(8 + i), 0, 0, 9, 11);
      chk("full_ready", DW'(bus.ld_ready), DW'(0));
      step(0, 0, 0, 1, 12, 0, 0, 12, 0);
      chk("full_err", DW'(bus.proto_err), DW'(1));
      step(0, 0, 0, 0, 0, 1, 'h100, 8, 0);
      chk("full_ret_ready", DW'(bus.ld_ready), DW'(0));
      idle(8, 9);
      chk("full_drain_ready", DW'(bus.ld_ready), DW'(1));
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, DW'('h101 + i), 10, 11);
      idle(10, 11);
      idle(10, 11);
      do_reset(0);

      // r0 handling
      step(1, 0, 'h99, 0, 0, 0, 0, 0, 0);
      chk("r0_alu_rw", DW'(bus.regwrite), DW'(0));
      step(0, 0, 0, 1, 0, 0, 0, 0, 0);
      chk("r0_busy", DW'(bus.busy_1), DW'(0));
      step(0, 0, 0, 0, 0, 1, 'h5A, 0, 0);
      idle(0, 0);
      chk("r0_ld_rw", DW'(bus.regwrite), DW'(0));
      chk("r0_ld_d",  bus.write_data,    DW'('h5A));

      // Reset with two loads pending, then a stray return
      step(0, 0, 0, 1, 12, 0, 0, 12, 13);
      step(0, 0, 0, 1, 13, 0, 0, 12, 13);
      chk("pend_busy", DW'(bus.busy_1), DW'(1));
      do_reset(12);
      step(0, 0, 0, 0, 0, 1, 'hDEAD, 12, 13);
      chk("late_err", DW'(bus.proto_err), DW'(1));
      chk("late_rw",  DW'(bus.regwrite),  DW'(0));
      do_reset(0);

      // Randomized traffic, legal protocol
      for (int c = 0; c < 400; c++) begin
         if (c % 100 == 99) do_reset(0);
         av  = ($urandom_range(0, 1) == 1);
         ard = AW'($urandom);
         if (av && m_pending(ard)) av = 1'b0;
         iss = ($urandom_range(0, 2) == 0) && (mq.size() < DEPTH);
         ird = AW'($urandom_range(0, 7));
         lv  = (m_unreturned() > 0) && ($urandom_range(0, 1) == 1);
         s1  = (mq.size() > 0 && $urandom_range(0, 1) == 1)
               ? mq[$urandom_range(0, mq.size() - 1)].rd : AW'($urandom);
         s2  = AW'($urandom_range(0, 7));
         step(av, ard, $urandom, iss, ird, lv, $urandom, s1, s2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
